// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the interval-timer sequencer: timer register map,
// control-register bit positions and the sequencer FSM state encoding.
package timer_sequencer_pkg;

  // Timer register addresses (16-bit registers).
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  // Control register bit positions.
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_SETTLE,
    ST_WR_CTRL,
    ST_RUN,
    ST_ACK,
    ST_STOP_WR,
    ST_STOP_ACK,
    ST_SNAP_WR,
    ST_SNAP_RD_L,
    ST_SNAP_RD_H,
    ST_SNAP_DONE
  } state_t;

  // Control word that starts the counter with its interrupt enabled.
  function automatic logic [15:0] start_word(input logic continuous);
    logic [15:0] w;
    w              = '0;
    w[CTRL_ITO]    = 1'b1;
    w[CTRL_CONT]   = continuous;
    w[CTRL_START]  = 1'b1;
    return w;
  endfunction

  // Control word that halts the counter.
  function automatic logic [15:0] stop_word();
    logic [15:0] w;
    w            = '0;
    w[CTRL_STOP] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_sequencer.sv
// Sole Avalon-MM master of the interval timer: programs period and mode from
// a valid/ready config port, starts the counter, services and clears
// timeouts (one tick each), and reads back 32-bit counter snapshots.
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int unsigned MIN_PERIOD = 16,
  parameter int unsigned TICK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_continuous,
  output logic                  cfg_err,
  input  logic                  stop_req,
  input  logic                  snap_req,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  running,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic [15:0]           tmr_readdata,
  input  logic                  tmr_irq
);

  state_t                state_q, state_d;
  logic [31:0]           period_q, period_d;
  logic                  cont_q, cont_d;
  logic                  ret_run_q, ret_run_d;
  logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;
  logic [15:0]           snap_lo_q, snap_lo_d;
  logic [31:0]           snap_value_q, snap_value_d;
  logic                  snap_valid_q, snap_valid_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  tick_q, tick_d;
  logic                  running_q, running_d;
  logic [2:0]            addr_q, addr_d;
  logic                  cs_q, cs_d;
  logic [15:0]           wdata_q, wdata_d;

  // Next-state and data-path decode for the sequencer FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    period_d     = period_q;
    cont_d       = cont_q;
    ret_run_d    = ret_run_q;
    tick_count_d = tick_count_q;
    snap_lo_d    = snap_lo_q;
    snap_value_d = snap_value_q;
    snap_valid_d = 1'b0;
    cfg_err_d    = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (state_q == ST_RUN && tmr_irq) begin
          state_d      = ST_ACK;
          tick_count_d = tick_count_q + TICK_CNT_W'(1);
        end else if (stop_req) begin
          state_d = ST_STOP_WR;
        end else if (snap_req) begin
          state_d   = ST_SNAP_WR;
          ret_run_d = (state_q == ST_RUN);
        end else if (cfg_valid && cfg_ready_q) begin
          if (cfg_period < 32'(MIN_PERIOD)) begin
            cfg_err_d = 1'b1;
          end else begin
            period_d     = cfg_period;
            cont_d       = cfg_continuous;
            tick_count_d = '0;
            state_d      = ST_WR_PL;
          end
        end
      end
      ST_WR_PL:     state_d = ST_WR_PH;
      ST_WR_PH:     state_d = ST_SETTLE;
      ST_SETTLE:    state_d = ST_WR_CTRL;
      ST_WR_CTRL:   state_d = ST_RUN;
      ST_ACK:       state_d = cont_q ? ST_RUN : ST_IDLE;
      ST_STOP_WR:   state_d = ST_STOP_ACK;
      ST_STOP_ACK:  state_d = ST_IDLE;
      ST_SNAP_WR:   state_d = ST_SNAP_RD_L;
      ST_SNAP_RD_L: state_d = ST_SNAP_RD_H;
      ST_SNAP_RD_H: begin
        // Read data lags the address by one cycle: this is snap_l.
        snap_lo_d = tmr_readdata;
        state_d   = ST_SNAP_DONE;
      end
      ST_SNAP_DONE: begin
        snap_value_d = {tmr_readdata, snap_lo_q};
        snap_valid_d = 1'b1;
        state_d      = ret_run_q ? ST_RUN : ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Bus and status outputs decoded from the next state so they register cleanly.
  always_comb begin
    addr_d      = ADDR_STATUS;
    cs_d        = 1'b0;
    wdata_d     = '0;
    cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
    tick_d      = (state_d == ST_ACK);
    running_d   = running_q;
    if (state_d == ST_RUN)       running_d = 1'b1;
    else if (state_d == ST_IDLE) running_d = 1'b0;
    case (state_d)
      ST_WR_PL:     begin cs_d = 1'b1; addr_d = ADDR_PERIOD_L; wdata_d = period_d[15:0];  end
      ST_WR_PH:     begin cs_d = 1'b1; addr_d = ADDR_PERIOD_H; wdata_d = period_d[31:16]; end
      ST_WR_CTRL:   begin cs_d = 1'b1; addr_d = ADDR_CONTROL;  wdata_d = start_word(cont_d); end
      ST_ACK:       begin cs_d = 1'b1; addr_d = ADDR_STATUS; end
      ST_STOP_WR:   begin cs_d = 1'b1; addr_d = ADDR_CONTROL;  wdata_d = stop_word(); end
      ST_STOP_ACK:  begin cs_d = 1'b1; addr_d = ADDR_STATUS; end
      ST_SNAP_WR:   begin cs_d = 1'b1; addr_d = ADDR_SNAP_L; end
      ST_SNAP_RD_L: addr_d = ADDR_SNAP_L;
      ST_SNAP_RD_H: addr_d = ADDR_SNAP_H;
      default:      ;
    endcase
  end

  // State and output registers with synchronous reset; a reset mid-sequence
  // simply drops back to an idle bus.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      ret_run_q    <= 1'b0;
      tick_count_q <= '0;
      snap_lo_q    <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_ready_q  <= 1'b0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      addr_q       <= ADDR_STATUS;
      cs_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      ret_run_q    <= ret_run_d;
      tick_count_q <= tick_count_d;
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      cfg_err_q    <= cfg_err_d;
      cfg_ready_q  <= cfg_ready_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
      addr_q       <= addr_d;
      cs_q         <= cs_d;
      wdata_q      <= wdata_d;
    end
  end

  assign cfg_ready      = cfg_ready_q;
  assign cfg_err        = cfg_err_q;
  assign snap_valid     = snap_valid_q;
  assign snap_value     = snap_value_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign running        = running_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = ~cs_q;
  assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer with a behavioural interval-timer
// model on the bus and a write/tick log compared against expected sequences.
module tb_timer_sequencer;

  localparam int MIN_P = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_period = '0;
  logic        cfg_continuous = 1'b0;
  logic        cfg_err;
  logic        stop_req = 1'b0;
  logic        snap_req = 1'b0;
  logic        snap_valid;
  logic [31:0] snap_value;
  logic        tick;
  logic [15:0] tick_count;
  logic        running;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  timer_sequencer #(.MIN_PERIOD(16), .TICK_CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_period(cfg_period),
    .cfg_continuous(cfg_continuous), .cfg_err(cfg_err),
    .stop_req(stop_req), .snap_req(snap_req),
    .snap_valid(snap_valid), .snap_value(snap_value),
    .tick(tick), .tick_count(tick_count), .running(running),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural interval timer ----------------
  logic [31:0] t_per, t_cnt, t_snap;
  logic        t_run, t_cont, t_irq, force_snap;
  logic        bus_wr;
  assign bus_wr  = tmr_chipselect && !tmr_write_n;
  assign tmr_irq = t_irq;

  always @(posedge clk) begin
    if (!reset_n) begin
      t_per <= '0; t_cnt <= '0; t_snap <= '0; t_run <= 1'b0; t_cont <= 1'b0;
      t_irq <= 1'b0; tmr_readdata <= '0;
    end else begin
      if (bus_wr) begin
        case (tmr_address)
          3'd0: t_irq <= 1'b0;
          3'd1: if (tmr_writedata[3]) t_run <= 1'b0;
                else if (tmr_writedata[2]) begin
                  t_run <= 1'b1; t_cont <= tmr_writedata[1]; t_cnt <= t_per;
                end
          3'd2: begin t_per[15:0] <= tmr_writedata; t_run <= 1'b0; end
          3'd3: begin
                  t_per[31:16] <= tmr_writedata; t_run <= 1'b0;
                  t_cnt <= {tmr_writedata, t_per[15:0]};
                end
          3'd4: t_snap <= force_snap ? 32'h0000_8123 : t_cnt;
          default: ;
        endcase
      end
      if (t_run && !(bus_wr && tmr_address inside {3'd1, 3'd2, 3'd3})) begin
        if (t_cnt == 0) begin
          t_irq <= 1'b1;
          if (t_cont) t_cnt <= t_per;
          else        t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      tmr_readdata <= (tmr_address == 3'd4) ? t_snap[15:0] :
                      (tmr_address == 3'd5) ? t_snap[31:16] : 16'h0;
    end
  end

  // ---------------- bus / tick monitor ----------------
  typedef struct { int cyc; logic [2:0] a; logic [15:0] d; } wr_t;
  wr_t wr_q[$];
  wr_t exp_q[$];
  int  tick_q[$];

  always @(negedge clk) begin
    if (reset_n) begin
      check("bus_strobe", {31'b0, tmr_chipselect}, {31'b0, ~tmr_write_n});
      if (bus_wr) wr_q.push_back('{cyc, tmr_address, tmr_writedata});
      if (tick) tick_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helper tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back('{0, a, d});
  endtask

  // Compares logged writes (address/data) with the expected list, then clears both.
  task automatic compare_writes(input string tag);
    check({tag, "_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), {13'b0, wr_q[i].a, wr_q[i].d},
            {13'b0, exp_q[i].a, exp_q[i].d});
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic do_cfg(input logic [31:0] p, input logic c, output int acc);
    int b = 0;
    @(negedge clk);
    while (!cfg_ready && b < 50) begin @(negedge clk); b++; end
    check("cfg_ready_wait", {31'b0, cfg_ready}, 32'd1);
    cfg_valid = 1'b1; cfg_period = p; cfg_continuous = c; acc = cyc;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int n, input int budget);
    int b = 0;
    while (tick_q.size() < n && b < budget) begin @(negedge clk); b++; end
    check("tick_wait", {31'b0, tick_q.size() >= n}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while (running && b < budget) begin @(negedge clk); b++; end
    check("idle_wait", {31'b0, running}, 32'd0);
  endtask

  // Checks the three programming writes and their cycle spacing; returns the start cycle.
  task automatic check_program(input logic [31:0] p, input logic c, input int acc, output int ctrl_cyc);
    logic [15:0] ctrl;
    ctrl = {13'b0, 1'b1, c, 1'b1};
    cycles(6);
    ctrl_cyc = 0;
    check("prog_count", {31'b0, wr_q.size() >= 3}, 32'd1);
    if (wr_q.size() >= 3) begin
      check("pl_write", {13'b0, wr_q[0].a, wr_q[0].d}, {13'b0, 3'd2, p[15:0]});
      check("ph_write", {13'b0, wr_q[1].a, wr_q[1].d}, {13'b0, 3'd3, p[31:16]});
      check("ctrl_write", {13'b0, wr_q[2].a, wr_q[2].d}, {13'b0, 3'd1, ctrl});
      check("pl_latency", wr_q[0].cyc - acc, 32'd1);
      check("settle_gap", wr_q[2].cyc - wr_q[1].cyc, 32'd2);
      check("start_latency", wr_q[2].cyc - acc, 32'd4);
      ctrl_cyc = wr_q[2].cyc;
      repeat (3) void'(wr_q.pop_front());
    end
  endtask

  typedef struct { logic [31:0] period; logic cont; logic exp_err; } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int acc, ctrl_cyc, p;
    p = int'(v.period);
    wr_q.delete(); tick_q.delete(); exp_q.delete();
    do_cfg(v.period, v.cont, acc);
    check($sformatf("v%0d_cfg_err", idx), {31'b0, cfg_err}, {31'b0, v.exp_err});
    if (v.exp_err) begin
      cycles(8);
      check("rej_no_writes", wr_q.size(), 32'd0);
      check("rej_ready", {31'b0, cfg_ready}, 32'd1);
      check("rej_running", {31'b0, running}, 32'd0);
      return;
    end
    check_program(v.period, v.cont, acc, ctrl_cyc);
    if (v.cont) begin
      wait_ticks(3, 4 * (p + 1) + 40);
      if (tick_q.size() >= 3) begin
        check("first_tick", tick_q[0] - ctrl_cyc, p + 3);
        check("tick_interval1", tick_q[1] - tick_q[0], p + 1);
        check("tick_interval2", tick_q[2] - tick_q[1], p + 1);
      end
      check("tick_count3", {16'b0, tick_count}, 32'd3);
      stop_req = 1'b1;
      wait_idle(20);
      stop_req = 1'b0;
      repeat (3) push_exp(3'd0, 16'h0);
      push_exp(3'd1, 16'h8);
      push_exp(3'd0, 16'h0);
      compare_writes("cont_stop");
    end else begin
      wait_ticks(1, p + 40);
      if (tick_q.size() >= 1) check("oneshot_tick", tick_q[0] - ctrl_cyc, p + 3);
      cycles(3);
      check("oneshot_running", {31'b0, running}, 32'd0);
      check("oneshot_count", {16'b0, tick_count}, 32'd1);
      cycles(200);
      check("oneshot_single", tick_q.size(), 32'd1);
      push_exp(3'd0, 16'h0);
      compare_writes("oneshot");
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[12];

  initial begin
    int acc, b;
    force_snap = 1'b0;

    // Table: spec cases and MIN_PERIOD boundaries, then randomized configs.
    vecs[0] = '{32'd99, 1'b1, 1'b0};
    vecs[1] = '{32'd20, 1'b0, 1'b0};
    vecs[2] = '{32'd5,  1'b1, 1'b1};
    vecs[3] = '{32'd15, 1'b0, 1'b1};
    vecs[4] = '{32'd16, 1'b1, 1'b0};
    vecs[5] = '{32'd16, 1'b0, 1'b0};
    for (int i = 6; i < 12; i++) begin
      vecs[i].period  = 32'($urandom_range(4, 40));
      vecs[i].cont    = 1'($urandom_range(0, 1));
      vecs[i].exp_err = (vecs[i].period < 32'(MIN_P));
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_cs", {31'b0, tmr_chipselect}, 32'd0);
    check("rst_write_n", {31'b0, tmr_write_n}, 32'd1);
    check("rst_addr", {29'b0, tmr_address}, 32'd0);
    check("rst_outs", {26'b0, cfg_ready, cfg_err, tick, running, snap_valid, 1'b0}, 32'd0);
    check("rst_tick_count", {16'b0, tick_count}, 32'd0);
    check("rst_snap_value", snap_value, 32'd0);
    reset_n = 1'b1;
    cycles(2);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Snapshot while running.
    wr_q.delete(); tick_q.delete();
    do_cfg(32'h0001_0000, 1'b1, acc);
    cycles(10);
    wr_q.delete();
    force_snap = 1'b1;
    snap_req = 1'b1;
    @(negedge clk); snap_req = 1'b0;
    check("snap_wr", {28'b0, tmr_chipselect, tmr_address}, {28'b0, 1'b1, 3'd4});
    @(negedge clk);
    check("snap_rd_l", {28'b0, tmr_chipselect, tmr_address}, {28'b0, 1'b0, 3'd4});
    @(negedge clk);
    check("snap_rd_h", {28'b0, tmr_chipselect, tmr_address}, {28'b0, 1'b0, 3'd5});
    @(negedge clk);
    check("snap_valid_early", {31'b0, snap_valid}, 32'd0);
    @(negedge clk);
    check("snap_valid", {31'b0, snap_valid}, 32'd1);
    check("snap_value", snap_value, 32'h0000_8123);
    check("snap_running", {31'b0, running}, 32'd1);
    @(negedge clk);
    check("snap_valid_pulse", {31'b0, snap_valid}, 32'd0);
    check("snap_held", snap_value, 32'h0000_8123);
    push_exp(3'd4, 16'h0);
    compare_writes("snap");
    force_snap = 1'b0;
    stop_req = 1'b1; wait_idle(20); stop_req = 1'b0;
    wr_q.delete();

    // stop_req in the same cycle the irq rises: ACK wins.
    tick_q.delete();
    do_cfg(32'd30, 1'b1, acc);
    b = 0;
    while (!tmr_irq && b < 100) begin @(negedge clk); b++; end
    check("irq_wait", {31'b0, tmr_irq}, 32'd1);
    wr_q.delete(); tick_q.delete();
    stop_req = 1'b1;
    @(negedge clk);
    check("race_ack_tick", {31'b0, tick}, 32'd1);
    wait_idle(20);
    stop_req = 1'b0;
    push_exp(3'd0, 16'h0);
    push_exp(3'd1, 16'h8);
    push_exp(3'd0, 16'h0);
    compare_writes("race");
    cycles(100);
    check("race_one_tick", tick_q.size(), 32'd1);

    // Reset during WR_PH, then a fresh config replays everything.
    do_cfg(32'd50, 1'b1, acc);
    @(negedge clk);
    check("in_wr_ph", {28'b0, tmr_chipselect, tmr_address}, {28'b0, 1'b1, 3'd3});
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_bus", {27'b0, tmr_chipselect, tmr_write_n, tmr_address}, {27'b0, 2'b01, 3'd0});
    check("rst_mid_flags", {29'b0, running, cfg_ready, tick}, 32'd0);
    reset_n = 1'b1;
    wr_q.delete();
    run_vec('{32'd50, 1'b0, 1'b0}, 99);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
